// File: rtl/datapath_pkg.sv
// Shared datapath definitions: responder FSM state encoding,
// access op encoding, default widths and the wait-counter width helper.
package datapath_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Wait counter width, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_datos_ram.sv
// Single-port synchronous data array: write-enable, registered read, no reset.
// Ports: clk, we, re, addr, din in; q out (updates only on re).
module mem_datos_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        if (re) q <= mem[addr];
    end

endmodule

// File: rtl/mem_datos_resp.sv
// Data-memory responder: accepts W/R strobes in IDLE, waits WAIT_CYC cycles,
// then commits the access and pulses DONE. Ports: CLK, RST, W, R, ADDR, DIN
// in; DOUT (last completed read), BUSY, DONE, ERR (W and R both high) out.
module mem_datos_resp
    import datapath_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WAIT_CYC = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              W,
    input  logic              R,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int CW = cnt_width(WAIT_CYC);
    localparam bit ZW = (WAIT_CYC == 0);
    localparam logic [CW-1:0] CNT_LOAD =
        ZW ? '0 : CW'(WAIT_CYC - 1);

    state_t            state;
    state_t            nxt;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    op_t               op_q;
    logic              err_q;
    logic              rd_ok;

    logic              acc_w;
    logic              acc_r;
    logic              fin;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_q;

    assign acc_w = (state == ST_IDLE) && W && !R;
    assign acc_r = (state == ST_IDLE) && R && !W;
    assign fin   = (state == ST_WAIT) && (cnt == '0);

    // With no wait cycles the access happens on the accepting edge,
    // so the RAM sees the live ADDR/DIN instead of the latched copies.
    always_comb begin
        ram_we = 1'b0;
        ram_re = 1'b0;
        if (ZW) begin
            ram_we = acc_w;
            ram_re = acc_r;
        end else begin
            ram_we = fin && (op_q == OP_WRITE);
            ram_re = fin && (op_q == OP_READ);
        end
        // Reset aborts any pending access.
        ram_we = ram_we && !RST;
        ram_re = ram_re && !RST;
    end

    assign ram_addr = (state == ST_IDLE) ? ADDR : a_q;
    assign ram_din  = (state == ST_IDLE) ? DIN : d_q;

    mem_datos_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk (CLK),
        .we  (ram_we),
        .re  (ram_re),
        .addr(ram_addr),
        .din (ram_din),
        .q   (ram_q)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (acc_w || acc_r)
                    nxt = ZW ? ST_DONE : ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == '0) nxt = ST_DONE;
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            a_q   <= '0;
            d_q   <= '0;
            op_q  <= OP_READ;
            err_q <= 1'b0;
            rd_ok <= 1'b0;
        end else begin
            err_q <= (state == ST_IDLE) && W && R;
            if (acc_w || acc_r) begin
                a_q  <= ADDR;
                op_q <= acc_w ? OP_WRITE : OP_READ;
                cnt  <= CNT_LOAD;
                if (acc_w) d_q <= DIN;
            end else if ((state == ST_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (ram_re) rd_ok <= 1'b1;
        end
    end

    // The array has no reset; rd_ok masks its read register until the
    // first read after reset so DOUT comes out of reset as zero.
    always_comb begin
        BUSY = (state != ST_IDLE);
        DONE = (state == ST_DONE);
        ERR  = err_q;
        DOUT = {DATA_W{rd_ok}} & ram_q;
    end

endmodule

// File: tb/tb_mem_datos_resp.sv
// Self-checking bench for mem_datos_resp with WAIT_CYC = 0, 1 and 3.
// Read expectations go through a scoreboard queue fed from a memory model.
module tb_mem_datos_resp;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  w;
    logic [2:0]  r;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  err;
    logic [4:0]  addr [3];
    logic [31:0] din  [3];
    logic [31:0] dout [3];

    int checks = 0;
    int failures = 0;
    int wcs [3] = '{0, 1, 3};

    typedef struct {
        int          inst;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] mdl [3][32];

    always #5 CLK = ~CLK;

    mem_datos_resp #(.DATA_W(32), .ADDR_W(5), .WAIT_CYC(0)) u0 (
        .CLK(CLK), .RST(RST), .W(w[0]), .R(r[0]),
        .ADDR(addr[0]), .DIN(din[0]), .DOUT(dout[0]),
        .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0])
    );

    mem_datos_resp #(.DATA_W(32), .ADDR_W(5), .WAIT_CYC(1)) u1 (
        .CLK(CLK), .RST(RST), .W(w[1]), .R(r[1]),
        .ADDR(addr[1]), .DIN(din[1]), .DOUT(dout[1]),
        .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1])
    );

    mem_datos_resp #(.DATA_W(32), .ADDR_W(5), .WAIT_CYC(3)) u2 (
        .CLK(CLK), .RST(RST), .W(w[2]), .R(r[2]),
        .ADDR(addr[2]), .DIN(din[2]), .DOUT(dout[2]),
        .BUSY(busy[2]), .DONE(done[2]), .ERR(err[2])
    );

    // Drive one request, scramble ADDR/DIN after acceptance, and wait
    // (bounded) for DONE. lat counts edges from the accepting edge.
    task automatic do_req(input int i, input bit wr,
                          input logic [4:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] q);
        @(negedge CLK);
        w[i] = wr;
        r[i] = !wr;
        addr[i] = a;
        din[i] = d;
        lat = 0;
        do begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
            w[i] = 1'b0;
            r[i] = 1'b0;
            addr[i] = 5'($urandom);
            din[i] = $urandom;
        end while (done[i] !== 1'b1 && lat < 20);
        q = dout[i];
    endtask

    task automatic wr_op(input int i, input logic [4:0] a,
                         input logic [31:0] d, output int lat);
        logic [31:0] q;
        do_req(i, 1'b1, a, d, lat, q);
        mdl[i][a] = d;
    endtask

    task automatic rd_op(input int i, input logic [4:0] a,
                         output int lat, output logic [31:0] q);
        exp_t e;
        e.inst = i;
        e.data = mdl[i][a];
        sbq.push_back(e);
        do_req(i, 1'b0, a, 32'h0, lat, q);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        w = '0;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            din[i] = '0;
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (busy !== 3'b000) begin
            failures++;
            $display("FAIL reset_busy: got %b want 000", busy);
        end
        checks++;
        if (done !== 3'b000) begin
            failures++;
            $display("FAIL reset_done: got %b want 000", done);
        end
        checks++;
        if (err !== 3'b000) begin
            failures++;
            $display("FAIL reset_err: got %b want 000", err);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout[i] !== 32'h0) begin
                failures++;
                $display("FAIL reset_dout%0d: got %h want 0", i, dout[i]);
            end
        end
        RST = 1'b0;
    endtask

    task automatic test_write_read();
        int lat;
        logic [31:0] q;
        exp_t e;
        wr_op(1, 5'd5, 32'hDEADBEEF, lat);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL wr_lat: got %0d want 2", lat);
        end
        checks++;
        if (dout[1] !== 32'h0) begin
            failures++;
            $display("FAIL dout_after_wr: got %h want 0", dout[1]);
        end
        rd_op(1, 5'd5, lat, q);
        e = sbq.pop_front();
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL rd_lat: got %0d want 2", lat);
        end
        checks++;
        if (q !== e.data) begin
            failures++;
            $display("FAIL rd_data: got %h want %h", q, e.data);
        end
        @(negedge CLK);
        checks++;
        if (done[1] !== 1'b0 || busy[1] !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse: got done=%b busy=%b want 0 0",
                     done[1], busy[1]);
        end
        wr_op(1, 5'd6, 32'h00000001, lat);
        checks++;
        if (dout[1] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL dout_hold: got %h want deadbeef", dout[1]);
        end
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        r[1] = 1'b1;
        addr[1] = 5'd5;
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        checks++;
        if (busy !== 3'b000 || done !== 3'b000 || err !== 3'b000) begin
            failures++;
            $display("FAIL async_rst: got busy=%b done=%b err=%b want 0",
                     busy, done, err);
        end
        checks++;
        if (dout[1] !== 32'h0) begin
            failures++;
            $display("FAIL async_rst_dout: got %h want 0", dout[1]);
        end
        @(negedge CLK);
        r[1] = 1'b0;
        RST = 1'b0;
    endtask

    task automatic test_illegal();
        int lat;
        logic [31:0] q;
        exp_t e;
        wr_op(1, 5'd9, 32'h00001234, lat);
        @(negedge CLK);
        w[1] = 1'b1;
        r[1] = 1'b1;
        addr[1] = 5'd9;
        din[1] = 32'hFFFFFFFF;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (k == 2) begin
                w[1] = 1'b0;
                r[1] = 1'b0;
            end
            checks++;
            if (err[1] !== 1'b1 || busy[1] !== 1'b0) begin
                failures++;
                $display("FAIL illegal_err%0d: got err=%b busy=%b want 1 0",
                         k, err[1], busy[1]);
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (err[1] !== 1'b0) begin
            failures++;
            $display("FAIL illegal_err_clear: got %b want 0", err[1]);
        end
        rd_op(1, 5'd9, lat, q);
        e = sbq.pop_front();
        checks++;
        if (q !== e.data) begin
            failures++;
            $display("FAIL illegal_mem: got %h want %h", q, e.data);
        end
    endtask

    task automatic test_busy_drop();
        int lat;
        int ndone;
        logic [31:0] q;
        exp_t e;
        wr_op(1, 5'd4, 32'h000000AA, lat);
        @(negedge CLK);
        w[1] = 1'b1;
        addr[1] = 5'd3;
        din[1] = 32'h11;
        @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL drop_busy: got %b want 1", busy[1]);
        end
        addr[1] = 5'd4;
        din[1] = 32'h22;
        @(posedge CLK);
        @(negedge CLK);
        w[1] = 1'b0;
        checks++;
        if (done[1] !== 1'b1) begin
            failures++;
            $display("FAIL drop_done: got %b want 1", done[1]);
        end
        mdl[1][3] = 32'h11;
        ndone = 0;
        repeat (6) begin
            @(posedge CLK);
            @(negedge CLK);
            if (done[1] === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL drop_extra_done: got %0d want 0", ndone);
        end
        rd_op(1, 5'd4, lat, q);
        e = sbq.pop_front();
        checks++;
        if (q !== e.data) begin
            failures++;
            $display("FAIL drop_mem4: got %h want %h", q, e.data);
        end
        rd_op(1, 5'd3, lat, q);
        e = sbq.pop_front();
        checks++;
        if (q !== e.data) begin
            failures++;
            $display("FAIL drop_mem3: got %h want %h", q, e.data);
        end
    endtask

    task automatic test_reset_mid_write();
        int lat;
        logic [31:0] q;
        exp_t e;
        wr_op(2, 5'd7, 32'h0000000A, lat);
        @(negedge CLK);
        w[2] = 1'b1;
        addr[2] = 5'd7;
        din[2] = 32'h55;
        @(posedge CLK);
        @(negedge CLK);
        w[2] = 1'b0;
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        checks++;
        if (busy[2] !== 1'b0 || dout[2] !== 32'h0) begin
            failures++;
            $display("FAIL midrst_out: got busy=%b dout=%h want 0 0",
                     busy[2], dout[2]);
        end
        @(negedge CLK);
        RST = 1'b0;
        rd_op(2, 5'd7, lat, q);
        e = sbq.pop_front();
        checks++;
        if (q !== e.data) begin
            failures++;
            $display("FAIL midrst_mem: got %h want %h", q, e.data);
        end
    endtask

    task automatic test_wait_cyc(input int i);
        int lat;
        logic [31:0] q;
        exp_t e;
        logic [4:0] a [2];
        logic [31:0] d [2];
        a[0] = 5'd31;
        a[1] = 5'd0;
        d[0] = 32'hCAFEF00D;
        d[1] = 32'h5A5A0000 + i;
        for (int k = 0; k < 2; k++) begin
            wr_op(i, a[k], d[k], lat);
            checks++;
            if (lat !== wcs[i] + 1) begin
                failures++;
                $display("FAIL wc%0d_wr_lat: got %0d want %0d",
                         wcs[i], lat, wcs[i] + 1);
            end
        end
        for (int k = 0; k < 2; k++) begin
            rd_op(i, a[k], lat, q);
            e = sbq.pop_front();
            checks++;
            if (lat !== wcs[i] + 1) begin
                failures++;
                $display("FAIL wc%0d_rd_lat: got %0d want %0d",
                         wcs[i], lat, wcs[i] + 1);
            end
            checks++;
            if (q !== e.data) begin
                failures++;
                $display("FAIL wc%0d_rd_data: got %h want %h",
                         wcs[i], q, e.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] q;
        logic [4:0] a;
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 2; i++) begin
                a = 5'($urandom);
                wr_op(i, a, $urandom, lat);
                rd_op(i, a, lat, q);
                e = sbq.pop_front();
                checks++;
                if (q !== e.data || e.inst != i) begin
                    failures++;
                    $display("FAIL b2b_inst%0d_a%0d: got %h want %h",
                             i, a, q, e.data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_async_reset();
        test_illegal();
        test_busy_drop();
        test_reset_mid_write();
        test_wait_cyc(0);
        test_wait_cyc(2);
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
